bram_arbiter: RTL

Two-port arbiter sharing one single-port block RAM between two requesters, e.g. CPU data port (m0) and UART loader/debug port (m1). Sits between the requesters and the BRAM inside `dut`. Grants by round-robin, issues one BRAM access per grant and returns a one-cycle acknowledge carrying read data. Back-to-back grants to alternating requesters sustain one access every 2 cycles.

---
 rtl/bram_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between two requesters.
// Each grant takes one ISSUE cycle and one ACK cycle.
module bram_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   localparam int BE_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [BE_W-1:0]   m0_be,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [BE_W-1:0]   m1_be,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              bram_en,
   output logic [BE_W-1:0]   bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   input  logic [DATA_W-1:0] bram_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

   state_t state_reg, state_next;
   logic   owner_reg, owner_next;
   logic   last_reg, last_next;
   logic [1:0] ack_vec;

   // last resets to 1 so that m0 wins the first tie
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         owner_reg <= 1'b0;
         last_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         last_reg  <= last_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            if (m0_req || m1_req) begin
               state_next = ISSUE;
               owner_next = (m0_req && m1_req) ? ~last_reg : m1_req;
            end
         end
         ISSUE: begin
            last_next  = owner_reg;
            state_next = ACK;
         end
         ACK: begin
            // only the other port can be granted straight from ACK; the acked
            // port's req is still high here and must not be taken as new
            if (owner_reg ? m0_req : m1_req) begin
               owner_next = ~owner_reg;
               state_next = ISSUE;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bram_en    = 1'b0;
      bram_we    = '0;
      bram_addr  = '0;
      bram_wdata = '0;
      if (state_reg == ISSUE) begin
         bram_en = 1'b1;
         if (owner_reg) begin
            bram_addr  = m1_addr;
            bram_wdata = m1_wdata;
            bram_we    = m1_we ? m1_be : '0;
         end else begin
            bram_addr  = m0_addr;
            bram_wdata = m0_wdata;
            bram_we    = m0_we ? m0_be : '0;
         end
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == ACK) && (owner_reg == (gi == 1));
   end

   assign m0_ack   = ack_vec[0];
   assign m1_ack   = ack_vec[1];
   assign m0_rdata = ack_vec[0] ? bram_rdata : '0;
   assign m1_rdata = ack_vec[1] ? bram_rdata : '0;

endmodule
